elevator_call_panel: RTL and testbench
======================================

# elevator_call_panel

Request-side front end for the 4-floor elevator controller. It synchronises and debounces raw floor-call buttons, latches each accepted call into a lamp register, and drives the controller's `req` input with one-cycle pulses. It clears each call when the controller reports service at that floor: `floor` matches and `door` is open. It also re-issues outstanding calls if the controller sits idle, so a request the controller did not act on is not lost.

## Interface
- `DB_CYCLES`, default 4: number of consecutive differing synchronised samples required before a button's debounced state toggles. Legal range is 1..255.
- `RETRY_CYCLES`, default 32: number of idle cycles with a call pending before all pending calls are re-pulsed. Legal range is 2..65535.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn`  in  4  raw floor-call buttons, asynchronous and may bounce; bit i is floor i.
- `floor`  in  2  controller's current floor.
- `moving`  in  1  controller's car-moving flag.
- `door`  in  1  controller's door-open flag.
- `req`  out  4  registered request pulses to the controller; bit i is floor i.
- `lamp`  out  4  registered pending-call lamps; bit i is floor i.
- `pending_any`  out  1  registered; equals the OR of `lamp`.

## Operation
- **Synchroniser:** two flops per bit produce `btn_s`.
- **Debounce, per bit:** the block holds a debounced `stable[i]` and an 8-bit counter `cnt[i]`.
  - If `btn_s[i] == stable[i]`: `cnt[i]` is cleared to 0.
  - Otherwise: `cnt[i]` increments. On the edge where it would reach `DB_CYCLES`, `stable[i]` toggles and `cnt[i]` is cleared to 0.
  - A press event `press[i]` is the 0→1 toggle of `stable[i]`. Release events have no effect.
- **Service condition:** `svc[i] = door && (floor == i)`.
- **Call latch:** on each edge, for each i, in this priority order:
  1. If `svc[i]`: `lamp[i]` is cleared to 0. This applies even if `press[i]` fires in the same cycle; service wins and no req is issued.
  2. Else if `press[i]` and `lamp[i] == 0`: `lamp[i]` is set to 1 and `new[i] = 1`.
  3. Else if `press[i]` and `lamp[i] == 1`: duplicate; ignored, no req.
- **Retry counter:** 16 bits.
  - Cleared to 0 whenever any of these holds: `lamp == 0`, `moving`, `door`, or `new != 0`.
  - Otherwise it increments.
  - On the edge where it would reach `RETRY_CYCLES`, it clears to 0 and `rty = 1` for that edge.
- **Request register:** the registered value of `req` is `new | (rty ? (lamp & ~svc) : 0)`.
  - Every bit is a single-cycle pulse.
  - A bit is never high on two consecutive cycles. A retry cannot coincide with `new`, because `new` clears the retry counter.
- **Reset:** `reset` low asynchronously forces all of the following to 0 with no clock edge required: `req`, `lamp`, `pending_any`, the synchroniser flops, `stable`, `cnt`, and the retry counter.
  - A button held through reset is treated as a fresh press after reset release, subject to the normal latency.
- **No-FSM note:** the block has no state machine beyond the per-bit debounce and the retry counter. The controller's direction policy is not modelled.

## Timing
- **Press latency:** let E0 be the first edge at which `btn[i] = 1` is sampled, with the button held steady afterwards.
  - `lamp[i]`, `pending_any`, and `req[i]` become 1 on edge E0 + DB_CYCLES + 1.
  - `req[i]` returns to 0 on the following edge.
- **Glitch rejection:** any `btn_s` excursion shorter than `DB_CYCLES` cycles produces no event.
- **Service clear:** if `svc[i]` is sampled true at edge E, then `lamp[i]` = 0 from edge E.
  - A press completing debounce at edge E is discarded.
  - A press completing debounce at edge E+1 after the door has closed is a new call.
- **Retry timing:** let E be the edge at which the idle-with-pending condition begins, i.e. the first edge where none of the clear conditions hold.
  - The first retry pulse occurs at edge E + RETRY_CYCLES − 1.
  - Retries then repeat every `RETRY_CYCLES` edges while the idle condition holds.
- **Counter width:** all counters saturate-free. The parameter ranges guarantee no wrap before the terminal compare.
- **Outputs:** registered; none are combinational from inputs.

## Test plan
- **Single call:** `DB_CYCLES` = 4; `btn` = 0100 held 10 cycles from E0 → `req` = 0100 for exactly one cycle at E0+5 and `lamp` = 0100. Then drive `floor` = 2, `door` = 1 → `lamp` = 0000 and `pending_any` = 0 on the next edge.
- **Bounce:** `btn[3]` toggling every 2 cycles for 16 cycles → `req` stays 0000 and `lamp` stays 0000. Then hold it high → exactly one `req` = 1000 pulse after DB_CYCLES+1 edges.
- **Duplicate and multi-call:** press `btn[1]`, release, press again while `lamp[1]` = 1 → exactly one `req` = 0010 pulse. Pressing 1100 simultaneously → a single `req` = 1100 pulse and `lamp` = 1110.
- **Press at serviced floor:** `floor` = 1, `door` = 1 held; press `btn[1]` → no `req`, `lamp[1]` stays 0. Press `btn[0]` in the same conditions → `req` = 0001 pulse.
- **Retry:** `lamp` = 0001 with `moving` = 0 and `door` = 0 for 70 cycles, `RETRY_CYCLES` = 32 → `req` = 0001 pulses 32 edges apart. Raising `moving` stops retries and clears the counter.
- **Reset mid-operation:** `lamp` = 1010 and a retry count in progress; drive `reset` low between edges → `lamp`, `req`, and `pending_any` read 0 immediately. `btn[2]` held through reset → `req` = 0100 at DB_CYCLES+1 edges after the first post-release sampling edge.

Source files
------------

// File: rtl/elevator_call_panel.sv
// Request-side front end for a 4-floor elevator controller: synchronises and debounces
// floor-call buttons, latches calls into lamps, pulses req, and re-issues calls while idle.
module elevator_call_panel #(
    parameter int DB_CYCLES    = 4,
    parameter int RETRY_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [1:0] floor,
    input  logic       moving,
    input  logic       door,
    output logic [3:0] req,
    output logic [3:0] lamp,
    output logic       pending_any
);

    logic [3:0]      sync1;
    logic [3:0]      btn_s;
    logic [3:0]      stable;
    logic [3:0][7:0] cnt;
    logic [15:0]     rty_cnt;

    logic [3:0]      svc;
    logic [3:0]      db_hit;
    logic [3:0]      press;
    logic [3:0]      new_call;
    logic [3:0]      stable_next;
    logic [3:0][7:0] cnt_next;
    logic [3:0]      lamp_next;
    logic [3:0]      req_next;
    logic [15:0]     rty_cnt_next;
    logic            idle;
    logic            rty;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        svc          = '0;
        db_hit       = '0;
        press        = '0;
        new_call     = '0;
        stable_next  = stable;
        cnt_next     = '0;
        lamp_next    = lamp;
        for (int i = 0; i < 4; i++) begin
            svc[i] = door && (floor == 2'(i));
            if (btn_s[i] != stable[i]) begin
                // Terminal compare on cnt+1 == DB_CYCLES, written as cnt == DB_CYCLES-1.
                db_hit[i] = (cnt[i] == 8'(DB_CYCLES - 1));
                if (db_hit[i]) begin
                    stable_next[i] = ~stable[i];
                end else begin
                    cnt_next[i] = cnt[i] + 8'd1;
                end
            end
            press[i] = db_hit[i] && !stable[i];
            if (svc[i]) begin
                lamp_next[i] = 1'b0;
            end else if (press[i] && !lamp[i]) begin
                lamp_next[i] = 1'b1;
                new_call[i]  = 1'b1;
            end
        end

        // Retry only while a call is pending and the controller is idle with the door shut.
        idle         = (lamp != 4'b0000) && !moving && !door && (new_call == 4'b0000);
        rty          = idle && (rty_cnt == 16'(RETRY_CYCLES - 1));
        rty_cnt_next = (!idle || rty) ? 16'd0 : rty_cnt + 16'd1;
        req_next     = new_call | (rty ? (lamp & ~svc) : 4'b0000);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: the per-bit debounce counters are reset along with everything else; they
    // are few and a known start value is needed for deterministic press latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1       <= '0;
            btn_s       <= '0;
            stable      <= '0;
            cnt         <= '0;
            rty_cnt     <= '0;
            lamp        <= '0;
            req         <= '0;
            pending_any <= 1'b0;
        end else begin
            sync1       <= btn;
            btn_s       <= sync1;
            stable      <= stable_next;
            cnt         <= cnt_next;
            rty_cnt     <= rty_cnt_next;
            lamp        <= lamp_next;
            req         <= req_next;
            pending_any <= |lamp_next;
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed self-checking bench for elevator_call_panel (DB_CYCLES=4, RETRY_CYCLES=32).
module tb_elevator_call_panel;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic [1:0] floor;
    logic       moving;
    logic       door;
    logic [3:0] req;
    logic [3:0] lamp;
    logic       pending_any;

    int n_checks = 0;
    int n_pass   = 0;

    elevator_call_panel #(
        .DB_CYCLES   (4),
        .RETRY_CYCLES(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .floor      (floor),
        .moving     (moving),
        .door       (door),
        .req        (req),
        .lamp       (lamp),
        .pending_any(pending_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect req == 0 for lat-1 edges, req == exp on the lat-th edge, then 0 again.
    task automatic wait_req(input string tag, input logic [3:0] exp, input int lat);
        for (int k = 1; k < lat; k++) begin
            tick();
            check({tag, "_quiet"}, req, 4'b0000);
        end
        tick();
        check({tag, "_pulse"}, req, exp);
        tick();
        check({tag, "_drop"}, req, 4'b0000);
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset  = 1'b1;
        btn    = 4'b0000;
        floor  = 2'd0;
        moving = 1'b1;
        door   = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_lamp", lamp, 4'b0000);
        check("rst_req", req, 4'b0000);
        check("rst_pend", {3'b000, pending_any}, 4'b0000);
        tick();
        tick();
        #2 reset = 1'b1;
        tick();

        // Single call on floor 2, then service it.
        btn = 4'b0100;
        wait_req("single", 4'b0100, 6);
        idle_ticks(3);
        check("single_lamp", lamp, 4'b0100);
        check("single_pend", {3'b000, pending_any}, 4'b0001);
        btn   = 4'b0000;
        floor = 2'd2;
        door  = 1'b1;
        tick();
        check("svc_lamp", lamp, 4'b0000);
        check("svc_pend", {3'b000, pending_any}, 4'b0000);
        door = 1'b0;
        idle_ticks(8);

        // Bounce on btn[3]: 2-cycle excursions are rejected.
        for (int k = 0; k < 16; k++) begin
            btn[3] = ((k / 2) % 2) == 0;
            tick();
            check("bounce_req", req, 4'b0000);
            check("bounce_lamp", lamp, 4'b0000);
        end
        btn = 4'b1000;
        wait_req("bounce_hold", 4'b1000, 6);
        check("bounce_hold_lamp", lamp, 4'b1000);
        floor = 2'd3;
        door  = 1'b1;
        tick();
        check("clr3_lamp", lamp, 4'b0000);
        btn  = 4'b0000;
        door = 1'b0;
        idle_ticks(8);

        // Duplicate press on floor 1, then simultaneous floors 2 and 3.
        btn = 4'b0010;
        wait_req("dup_first", 4'b0010, 6);
        btn = 4'b0000;
        idle_ticks(8);
        btn = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("dup_again_req", req, 4'b0000);
        end
        check("dup_lamp", lamp, 4'b0010);
        btn = 4'b0000;
        idle_ticks(8);
        btn = 4'b1100;
        wait_req("multi", 4'b1100, 6);
        check("multi_lamp", lamp, 4'b1110);
        btn  = 4'b0000;
        door = 1'b1;
        for (int f = 1; f < 4; f++) begin
            floor = 2'(f);
            tick();
        end
        check("multi_clear", lamp, 4'b0000);
        idle_ticks(8);

        // Press at the serviced floor is dropped; another floor is accepted.
        floor = 2'd1;
        btn   = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("atfloor_req", req, 4'b0000);
            check("atfloor_lamp", lamp, 4'b0000);
        end
        btn = 4'b0000;
        idle_ticks(8);
        btn = 4'b0001;
        wait_req("otherfloor", 4'b0001, 6);
        check("otherfloor_lamp", lamp, 4'b0001);
        btn = 4'b0000;
        idle_ticks(8);

        // Retry: idle with floor 0 pending.
        door   = 1'b0;
        moving = 1'b0;
        wait_req("retry1", 4'b0001, 32);
        wait_req("retry2", 4'b0001, 31);
        moving = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("moving_noretry", req, 4'b0000);
        end
        moving = 1'b0;
        wait_req("retry_restart", 4'b0001, 32);
        moving = 1'b1;

        // Reset mid-operation with btn[2] held through it.
        floor = 2'd0;
        door  = 1'b1;
        tick();
        door = 1'b0;
        check("clr0_lamp", lamp, 4'b0000);
        btn = 4'b1010;
        wait_req("pre_rst", 4'b1010, 6);
        check("pre_rst_lamp", lamp, 4'b1010);
        btn    = 4'b0000;
        moving = 1'b0;
        idle_ticks(10);
        check("pre_rst_held", lamp, 4'b1010);
        #2;
        btn   = 4'b0100;
        reset = 1'b0;
        #1;
        check("async_lamp", lamp, 4'b0000);
        check("async_req", req, 4'b0000);
        check("async_pend", {3'b000, pending_any}, 4'b0000);
        idle_ticks(3);
        check("in_rst_lamp", lamp, 4'b0000);
        #2 reset = 1'b1;
        wait_req("post_rst", 4'b0100, 6);
        check("post_rst_lamp", lamp, 4'b0100);
        check("post_rst_pend", {3'b000, pending_any}, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
